// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: instruction-fetch front end feeding the IF/ID pipeline register
//   clk, rst (async, active-low)    clock and reset
//   fetch_en                        allow fetching; low parks the block in IDLE
//   req_valid/req_ready/req_addr    fetch request to instruction memory
//   rsp_valid/rsp_data/rsp_err      in-order response, one per accepted request
//   redirect_valid/redirect_pc      flush and restart fetch at a new target
//   out_valid/out_ready             single-entry output buffer handshake
//   out_pc/out_inst/out_err         buffered PC, instruction and access-fault flag
module ifu_fetch_ctrl #(
    parameter int              PC_W     = 64,
    parameter int              INST_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = 64'h80000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [PC_W-1:0]   req_addr,
    input  logic              rsp_valid,
    input  logic [INST_W-1:0] rsp_data,
    input  logic              rsp_err,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic              out_err
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_HALT = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              drop_q, drop_d;
    logic              out_valid_q, out_valid_d;
    logic [PC_W-1:0]   out_pc_q, out_pc_d;
    logic [INST_W-1:0] out_inst_q, out_inst_d;
    logic              out_err_q, out_err_d;
    logic              can_issue, hs, redir, capture;

    // A new request may only go out if its response will find room in the buffer.
    assign can_issue = !out_valid_q || out_ready;
    assign req_valid = state_q == S_REQ && fetch_en && can_issue;
    assign req_addr  = pc_q & ~PC_W'(3);
    assign hs        = req_valid && req_ready;
    // Redirect is ignored only while parked in IDLE with fetching disabled.
    assign redir     = redirect_valid && (state_q != S_IDLE || fetch_en);
    assign capture   = state_q == S_WAIT && rsp_valid && !drop_q && !redir;

    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_inst  = out_inst_q;
    assign out_err   = out_err_q;

    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        pc_d        = redir ? (redirect_pc & ~PC_W'(3)) : (capture && !rsp_err) ? pc_q + PC_W'(4) : pc_q;
        out_valid_d = redir ? 1'b0 : capture ? 1'b1 : (out_valid_q && out_ready) ? 1'b0 : out_valid_q;
        out_pc_d    = capture ? pc_q : out_pc_q;
        out_inst_d  = capture ? rsp_data : out_inst_q;
        out_err_d   = capture ? rsp_err : out_err_q;
        case (state_q)
            S_IDLE: state_d = fetch_en ? S_REQ : S_IDLE;
            S_REQ: begin
                // A redirect racing an accepted request must discard that request's response.
                if (hs) begin
                    state_d = S_WAIT;
                    drop_d  = redir;
                end else if (!redir) begin
                    state_d = !can_issue ? S_HOLD : fetch_en ? S_REQ : S_IDLE;
                end
            end
            S_WAIT: begin
                if (rsp_valid) begin
                    state_d = (capture && rsp_err) ? S_HALT : S_REQ;
                    drop_d  = 1'b0;
                end else if (redir) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: state_d = redir ? S_REQ : !out_ready ? S_HOLD : fetch_en ? S_REQ : S_IDLE;
            S_HALT: state_d = redir ? S_REQ : S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_inst_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
            out_err_q   <= out_err_d;
        end
    end
endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb_ifu_fetch_ctrl: directed and randomized checks of ifu_fetch_ctrl against a transaction-level model
module tb_ifu_fetch_ctrl;
    localparam logic [63:0] RST_PC = 64'h80000000;

    logic        clk = 0, rst = 0, fetch_en = 0, req_ready = 0, rsp_valid = 0, rsp_err = 0;
    logic        redirect_valid = 0, out_ready = 1;
    logic [63:0] redirect_pc = 0;
    logic [31:0] rsp_data = 0;
    logic        req_valid, out_valid, out_err;
    logic [63:0] req_addr, out_pc;
    logic [31:0] out_inst;

    always #5 clk = ~clk;

    ifu_fetch_ctrl dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_inst(out_inst), .out_err(out_err)
    );

    int errors = 0, checks = 0;
    int lat = 1, cnt = 0, cyc = 0, caps = 0, hs_cyc = 0;
    logic        rand_mode = 0;
    logic [63:0] err_at = '1;
    logic        m_valid, m_err, m_halt, m_outst, m_live;
    logic [63:0] m_pc, e_pc, r_pc;
    logic [31:0] m_inst;
    logic        s_req_valid, s_out_valid, s_out_err, hs_seen;
    logic [63:0] s_req_addr, s_out_pc, hs_addr;
    logic [31:0] s_out_inst;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_err = 0; m_halt = 0; m_outst = 0; m_live = 0;
        m_pc = 0; m_inst = 0; e_pc = RST_PC; r_pc = 0; cnt = 0;
    endtask

    task automatic do_reset();
        rst = 0; fetch_en = 0; req_ready = 0; out_ready = 1; redirect_valid = 0;
        rsp_valid = 0; rsp_err = 0; rand_mode = 0; err_at = '1; lat = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1;
    endtask

    // One clock cycle: sample at negedge, check against the model, advance the model,
    // then play the memory side for the next cycle.
    task automatic tick();
        logic hs, rd, cap;
        @(negedge clk);
        s_req_valid = req_valid; s_req_addr = req_addr; s_out_valid = out_valid;
        s_out_pc = out_pc; s_out_inst = out_inst; s_out_err = out_err;
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("out_pc", out_pc, m_pc);
            chk("out_inst", out_inst, m_inst);
            chk("out_err", out_err, m_err);
        end
        if (m_outst || m_halt || (m_valid && !out_ready)) chk("req_blocked", req_valid, 0);
        hs = req_valid && req_ready;
        rd = redirect_valid;
        if (hs) chk("req_addr", req_addr, e_pc);
        hs_seen = hs; hs_addr = req_addr;
        if (hs) hs_cyc = cyc;
        cap = 0;
        if (rsp_valid) begin
            m_outst = 0;
            cap = m_live && !rd;
        end
        if (hs) begin
            m_outst = 1; m_live = 1; r_pc = e_pc; cnt = lat;
        end
        if (rd) begin
            m_live = 0; m_valid = 0; m_halt = 0; e_pc = redirect_pc & ~64'd3;
        end else if (cap) begin
            m_valid = 1; m_pc = r_pc; m_inst = rsp_data; m_err = rsp_err; caps++;
            if (rsp_err) m_halt = 1;
            else e_pc = r_pc + 64'd4;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        cyc++;
        @(posedge clk);
        #1;
        rsp_valid = 0; rsp_err = 0;
        if (m_outst && cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                rsp_valid = 1;
                rsp_data = rand_mode ? $urandom : 32'h00000013;
                rsp_err = rand_mode ? ($urandom_range(0, 15) == 0) : (r_pc == err_at);
            end
        end
    endtask

    task automatic next_hs(input string tag, input logic [63:0] addr);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!hs_seen && n < 20);
        chk({tag, "_seen"}, hs_seen, 1);
        chk(tag, hs_addr, addr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, caps0;
        do_reset();
        tick();
        chk("rst_req_valid", s_req_valid, 0);
        chk("rst_out_valid", s_out_valid, 0);
        chk("rst_out_pc", s_out_pc, 0);
        chk("rst_out_inst", s_out_inst, 0);
        chk("rst_out_err", s_out_err, 0);

        // sequential fetch, one-cycle memory
        fetch_en = 1; req_ready = 1;
        next_hs("t1_a0", RST_PC);
        next_hs("t1_a1", RST_PC + 64'd4);
        c0 = hs_cyc;
        next_hs("t1_a2", RST_PC + 64'd8);
        chk("t1_gap", 64'(hs_cyc - c0), 2);
        chk("t1_valid", s_out_valid, 1);
        chk("t1_pc", s_out_pc, RST_PC + 64'd4);
        chk("t1_inst", s_out_inst, 32'h00000013);

        // downstream stall holds the buffer and blocks requests
        do_reset();
        fetch_en = 1; req_ready = 1; out_ready = 0;
        next_hs("t2_a0", RST_PC);
        repeat (5) begin
            tick();
            chk("t2_hold_req", s_req_valid, 0);
        end
        chk("t2_valid", s_out_valid, 1);
        chk("t2_pc", s_out_pc, RST_PC);
        out_ready = 1;
        next_hs("t2_a1", RST_PC + 64'd4);

        // redirect in WAIT, stale response arrives later
        do_reset();
        fetch_en = 1; req_ready = 1; lat = 3;
        next_hs("t3_a0", RST_PC);
        redirect_valid = 1; redirect_pc = 64'h80001003; lat = 1;
        tick();
        redirect_valid = 0;
        repeat (2) begin
            tick();
            chk("t3_no_out", s_out_valid, 0);
        end
        next_hs("t3_a1", 64'h80001000);
        chk("t3_no_out2", s_out_valid, 0);

        // redirect coincides with the response
        redirect_valid = 1; redirect_pc = 64'h80002000;
        tick();
        redirect_valid = 0;
        tick();
        chk("t4_req_valid", s_req_valid, 1);
        chk("t4_req_addr", s_req_addr, 64'h80002000);
        chk("t4_no_out", s_out_valid, 0);
        tick();
        tick();
        chk("t4_cap_valid", s_out_valid, 1);
        chk("t4_cap_pc", s_out_pc, 64'h80002000);

        // access fault halts fetch until redirected
        do_reset();
        fetch_en = 1; req_ready = 1; err_at = 64'h80000010;
        for (int i = 0; i < 5; i++) next_hs("t5_seq", RST_PC + 64'(4 * i));
        tick();
        tick();
        chk("t5_err_valid", s_out_valid, 1);
        chk("t5_err", s_out_err, 1);
        chk("t5_err_pc", s_out_pc, 64'h80000010);
        repeat (4) begin
            tick();
            chk("t5_halt_req", s_req_valid, 0);
        end
        redirect_valid = 1; redirect_pc = 64'h80000100; err_at = '1;
        tick();
        redirect_valid = 0;
        next_hs("t5_resume", 64'h80000100);

        // asynchronous reset in the middle of WAIT
        do_reset();
        fetch_en = 1; req_ready = 1;
        next_hs("t6_a0", RST_PC);
        lat = 3;
        next_hs("t6_a1", RST_PC + 64'd4);
        #2 rst = 0;
        #1;
        chk("t6_out_valid", out_valid, 0);
        chk("t6_req_valid", req_valid, 0);
        chk("t6_out_pc", out_pc, 0);
        do_reset();
        fetch_en = 1; req_ready = 1;
        next_hs("t6_after", RST_PC);

        // randomized traffic against the model
        do_reset();
        fetch_en = 1; rand_mode = 1;
        caps0 = caps;
        repeat (3000) begin
            req_ready = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            lat = $urandom_range(1, 3);
            redirect_valid = $urandom_range(0, 24) == 0;
            redirect_pc = {$urandom, $urandom};
            tick();
        end
        redirect_valid = 0;
        chk("rand_progress", (caps - caps0) > 150, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
- Instruction-fetch front end; sits directly upstream of the IF/ID pipeline register.
- Owns the architectural fetch PC and issues fetch requests to the instruction memory over a valid/ready handshake.
- Captures returned instructions into a single-entry output buffer that drives the IF/ID register's PC/instruction inputs.
- Supports redirect (branch/jump/trap target) with discard of in-flight responses, downstream stall, and fetch-error halt.

Parameters:
PC_W, 64, fetch PC / address width
INST_W, 32, instruction width
RESET_PC, 64'h80000000, PC value loaded at reset

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
fetch_en  input  1  1 = fetching allowed; 0 = hold in IDLE
req_valid  output  1  fetch request valid
req_ready  input  1  memory accepts request
req_addr  output  PC_W  fetch address, always {pc[PC_W-1:2],2'b00}
rsp_valid  input  1  response valid (one per accepted request, in order)
rsp_data  input  INST_W  returned instruction
rsp_err  input  1  access fault, qualified by rsp_valid
redirect_valid  input  1  flush and redirect fetch
redirect_pc  input  PC_W  new fetch target; bits [1:0] ignored
out_valid  output  1  output buffer holds an instruction
out_ready  input  1  IF/ID register accepts this cycle
out_pc  output  PC_W  PC of buffered instruction
out_inst  output  INST_W  buffered instruction
out_err  output  1  buffered entry is an access fault

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, pc=RESET_PC, drop=0, req_valid=0, out_valid=0, out_pc=0, out_inst=0, out_err=0.
- States: IDLE, REQ, WAIT, HOLD, HALT.
- IDLE: req_valid=0. If fetch_en=1, go to REQ next cycle.
- REQ: req_valid=1, req_addr=pc.
  - Issue only when the buffer is empty or draining this cycle (out_valid=0 or out_ready=1); otherwise go to HOLD.
  - req_valid=1 && req_ready=1: go to WAIT.
  - Hold req_valid and req_addr stable until accepted, except on redirect.
- WAIT: req_valid=0. On rsp_valid:
  - drop=1: discard response, clear drop, go to REQ.
  - drop=0: out_pc<=pc, out_inst<=rsp_data, out_err<=rsp_err, out_valid<=1.
  - After capture: if rsp_err, go to HALT; else pc<=pc+4 (wraps modulo 2^PC_W) and go to REQ.
- HOLD: buffer full and out_ready=0; req_valid=0. Return to REQ the cycle after out_ready=1 drains the buffer.
- Buffer handshake: out_valid && out_ready pops the entry; out_valid falls next cycle unless a new response is captured the same cycle.
- Minimum latency: request accepted at cycle N, rsp_valid at N+1 → out_valid at N+2. Back-to-back throughput is one instruction per 2 cycles.
- HALT: req_valid=0. Stays here until redirect_valid. fetch_en is ignored.
- Redirect (highest priority, any state except IDLE with fetch_en=0):
  - pc<={redirect_pc[PC_W-1:2],2'b00}; out_valid<=0 (buffer flushed even if out_ready=1 the same cycle).
  - WAIT with no rsp_valid this cycle: drop<=1, stay in WAIT.
  - WAIT with rsp_valid this cycle: response discarded, drop<=0, go to REQ.
  - REQ with handshake this cycle: drop<=1, go to WAIT.
  - REQ without handshake: stay in REQ; req_addr shows the new target next cycle.
  - HOLD / HALT: go to REQ.
- fetch_en falling mid-operation: an outstanding request still completes and is captured. Return to IDLE from REQ/HOLD once the buffer is empty.
- Only one outstanding request at any time.

Test Plan:
- Reset release, fetch_en=1, req_ready=1, memory returns 0x00000013 with 1-cycle latency → req_addr 0x80000000, 0x80000004, 0x80000008…; out_pc matches; out_inst=0x00000013.
- out_ready=0 for 5 cycles after first capture → state HOLD, req_valid=0, out_pc stays 0x80000000; out_ready=1 → next req_addr=0x80000004.
- redirect_valid with redirect_pc=0x80001003 while in WAIT, response arrives 2 cycles later → response discarded, out_valid stays 0, next req_addr=0x80001000.
- redirect_valid and rsp_valid in the same WAIT cycle → no capture, next cycle req_addr=redirect target, drop=0.
- rsp_err=1 at pc 0x80000010 → out_err=1, out_pc=0x80000010, req_valid stays 0 in HALT until redirect to 0x80000100, then fetch resumes there.
- Assert rst=0 asynchronously mid-WAIT → out_valid, req_valid drop immediately; after release first req_addr=0x80000000.
